id_ex_stage: RTL and testbench

//  ID/EX pipeline register and operand-forwarding stage that feeds the 16-bit ALU.
//  It captures the decoded instruction each cycle and resolves operand hazards from EX/MEM and MEM/WB.
//  It presents A, B and Sigs to the ALU, together with the destination and control bits that travel with the instruction.
//  It also detects load-use hazards and inserts bubbles.

---
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion
// for the 16-bit ALU. All outputs are registered fields, apart from the forwarded
// operands and the load-use stall request, which are combinational.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3,
  parameter int SIG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [SIG_W-1:0]  in_sigs,
  input  logic [RA_W-1:0]   in_rs_addr,
  input  logic [RA_W-1:0]   in_rt_addr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [RA_W-1:0]   in_rd_addr,
  input  logic              in_wr_en,
  input  logic              in_is_load,
  input  logic              in_setcc,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_wr_en,
  input  logic [RA_W-1:0]   exmem_rd_addr,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr_en,
  input  logic [RA_W-1:0]   memwb_rd_addr,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SIG_W-1:0]  alu_sigs,
  output logic              ex_valid,
  output logic [RA_W-1:0]   ex_rd_addr,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic              ex_setcc,
  output logic              load_use_stall
);

  logic              valid_q;
  logic [SIG_W-1:0]  sigs_q;
  logic [RA_W-1:0]   rs_addr_q;
  logic [RA_W-1:0]   rt_addr_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic              use_imm_q;
  logic [RA_W-1:0]   rd_addr_q;
  logic              wr_en_q;
  logic              is_load_q;
  logic              setcc_q;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              rd_match;
  logic              lu_hazard;

  // Forward the freshest producer onto each registered source; r0 is hard zero.
  always_comb begin
    fwd_a = rs_data_q;
    if (rs_addr_q == '0)
      fwd_a = '0;
    else if (exmem_wr_en && (exmem_rd_addr == rs_addr_q))
      fwd_a = exmem_data;
    else if (memwb_wr_en && (memwb_rd_addr == rs_addr_q))
      fwd_a = memwb_data;

    fwd_b = rt_data_q;
    if (rt_addr_q == '0)
      fwd_b = '0;
    else if (exmem_wr_en && (exmem_rd_addr == rt_addr_q))
      fwd_b = exmem_data;
    else if (memwb_wr_en && (memwb_rd_addr == rt_addr_q))
      fwd_b = memwb_data;
  end

  // A load in EX cannot forward in time to a dependent instruction waiting in ID.
  always_comb begin
    rd_match  = (rd_addr_q != '0) &&
                ((in_rs_addr == rd_addr_q) || (!in_use_imm && (in_rt_addr == rd_addr_q)));
    lu_hazard = valid_q && is_load_q && in_valid && rd_match;
  end

  // Pipeline register: flush beats stall beats load-use bubble beats normal capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      sigs_q    <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      is_load_q <= 1'b0;
      setcc_q   <= 1'b0;
    end else if (flush || (!stall && (lu_hazard || !in_valid))) begin
      valid_q   <= 1'b0;
      sigs_q    <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      is_load_q <= 1'b0;
      setcc_q   <= 1'b0;
    end else if (stall) begin
      // capture forwarded values so results retiring during the hold are not lost
      rs_data_q <= fwd_a;
      rt_data_q <= fwd_b;
    end else begin
      valid_q   <= 1'b1;
      sigs_q    <= in_sigs;
      rs_addr_q <= in_rs_addr;
      rt_addr_q <= in_rt_addr;
      rs_data_q <= in_rs_data;
      rt_data_q <= in_rt_data;
      imm_q     <= in_imm;
      use_imm_q <= in_use_imm;
      rd_addr_q <= in_rd_addr;
      wr_en_q   <= in_wr_en;
      is_load_q <= in_is_load;
      setcc_q   <= in_setcc;
    end
  end

  // Output presentation; control bits are qualified by the valid flag.
  always_comb begin
    alu_a          = fwd_a;
    alu_b          = use_imm_q ? imm_q : fwd_b;
    alu_sigs       = sigs_q;
    ex_valid       = valid_q;
    ex_rd_addr     = rd_addr_q;
    ex_wr_en       = valid_q & wr_en_q;
    ex_is_load     = valid_q & is_load_q;
    ex_setcc       = valid_q & setcc_q;
    load_use_stall = lu_hazard;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a model of what the EX stage holds, a per-cycle compare
// against it, and directed scenarios with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_sigs;
  logic [2:0]  in_rs_addr, in_rt_addr, in_rd_addr;
  logic [15:0] in_rs_data, in_rt_data, in_imm;
  logic        in_use_imm, in_wr_en, in_is_load, in_setcc;
  logic        stall, flush;
  logic        exmem_wr_en, memwb_wr_en;
  logic [2:0]  exmem_rd_addr, memwb_rd_addr;
  logic [15:0] exmem_data, memwb_data;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_sigs;
  logic        ex_valid, ex_wr_en, ex_is_load, ex_setcc, load_use_stall;
  logic [2:0]  ex_rd_addr;

  int checks = 0;
  int failures = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sigs(in_sigs),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr), .in_wr_en(in_wr_en),
    .in_is_load(in_is_load), .in_setcc(in_setcc), .stall(stall), .flush(flush),
    .exmem_wr_en(exmem_wr_en), .exmem_rd_addr(exmem_rd_addr), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sigs(alu_sigs), .ex_valid(ex_valid),
    .ex_rd_addr(ex_rd_addr), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_setcc(ex_setcc), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // Instruction currently in EX, as the architecture sees it.
  typedef struct packed {
    logic        valid;
    logic [3:0]  sigs;
    logic [2:0]  rs, rt, rd;
    logic [15:0] rs_val, rt_val, imm;
    logic        use_imm, wr, ld, cc;
  } ex_t;

  ex_t m;

  // Architectural value of register a: r0 is zero, otherwise newest in-flight producer.
  function automatic logic [15:0] reg_val(input logic [2:0] a, input logic [15:0] stored);
    if (a == 3'd0) return 16'h0;
    if (exmem_wr_en && exmem_rd_addr == a) return exmem_data;
    if (memwb_wr_en && memwb_rd_addr == a) return memwb_data;
    return stored;
  endfunction

  function automatic logic model_lus();
    logic dep;
    dep = (in_rs_addr == m.rd) || (!in_use_imm && in_rt_addr == m.rd);
    return m.valid && m.ld && in_valid && (m.rd != 3'd0) && dep;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else if (flush) m <= '0;
    else if (stall) begin
      m.rs_val <= reg_val(m.rs, m.rs_val);
      m.rt_val <= reg_val(m.rt, m.rt_val);
    end else if (model_lus() || !in_valid) m <= '0;
    else m <= '{1'b1, in_sigs, in_rs_addr, in_rt_addr, in_rd_addr,
                in_rs_data, in_rt_data, in_imm, in_use_imm, in_wr_en, in_is_load, in_setcc};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_alu_a", 32'(alu_a), 32'(reg_val(m.rs, m.rs_val)));
    chk("m_alu_b", 32'(alu_b), 32'(m.use_imm ? m.imm : reg_val(m.rt, m.rt_val)));
    chk("m_sigs", 32'(alu_sigs), 32'(m.sigs));
    chk("m_valid", 32'(ex_valid), 32'(m.valid));
    chk("m_rd", 32'(ex_rd_addr), 32'(m.rd));
    chk("m_wr_en", 32'(ex_wr_en), 32'(m.valid & m.wr));
    chk("m_is_load", 32'(ex_is_load), 32'(m.valid & m.ld));
    chk("m_setcc", 32'(ex_setcc), 32'(m.valid & m.cc));
    chk("m_lus", 32'(load_use_stall), 32'(model_lus()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                        input logic ui, input logic [2:0] rd, input logic wr, input logic ld, input logic cc);
    in_valid = v; in_sigs = s; in_rs_addr = rs; in_rt_addr = rt; in_rs_data = rsd;
    in_rt_data = rtd; in_imm = imm; in_use_imm = ui; in_rd_addr = rd;
    in_wr_en = wr; in_is_load = ld; in_setcc = cc;
  endtask

  task automatic set_fwd(input logic ew, input logic [2:0] er, input logic [15:0] ed,
                         input logic mw, input logic [2:0] mr, input logic [15:0] md);
    exmem_wr_en = ew; exmem_rd_addr = er; exmem_data = ed;
    memwb_wr_en = mw; memwb_rd_addr = mr; memwb_data = md;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(0, 4'h0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0, 0);
    set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    #2;
    chk("reset_valid", 32'(ex_valid), 32'h0);
    chk("reset_sigs", 32'(alu_sigs), 32'h0);
    chk("reset_ab", {alu_a, alu_b}, 32'h0);
    #10 rst_n = 1'b1;

    // forwarding priority: EX/MEM over MEM/WB over registered data
    set_id(1, 4'b0100, 3'd3, 3'd1, 16'h0AAA, 16'h0005, 16'h0, 0, 3'd4, 1, 0, 1);
    tick();
    chk("plain_a", 32'(alu_a), 32'h0AAA);
    chk("plain_b", 32'(alu_b), 32'h0005);
    set_fwd(1, 3'd3, 16'h2314, 1, 3'd3, 16'h1111);
    #1 chk("fwd_exmem", 32'(alu_a), 32'h2314);
    exmem_wr_en = 1'b0;
    #1 chk("fwd_memwb", 32'(alu_a), 32'h1111);

    // r0 never forwards; immediate bypasses forwarding
    set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    set_id(1, 4'b0000, 3'd0, 3'd6, 16'h1234, 16'h0777, 16'h8043, 1, 3'd1, 1, 0, 0);
    tick();
    set_fwd(1, 3'd0, 16'hFFFF, 0, 3'd0, 16'h0);
    #1 chk("r0_zero", 32'(alu_a), 32'h0);
    exmem_rd_addr = 3'd6; exmem_data = 16'hBEEF;
    #1 chk("imm_nofwd", 32'(alu_b), 32'h8043);
    set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);

    // load-use: load r5 then a reader of r5
    set_id(1, 4'b0100, 3'd1, 3'd2, 16'h0010, 16'h0020, 16'h0, 0, 3'd5, 1, 1, 0);
    tick();
    set_id(1, 4'b0101, 3'd5, 3'd2, 16'h0050, 16'h0020, 16'h0, 0, 3'd3, 1, 0, 1);
    #1 chk("lus_raise", 32'(load_use_stall), 32'h1);
    tick();
    chk("lus_bubble_v", 32'(ex_valid), 32'h0);
    chk("lus_bubble_s", 32'(alu_sigs), 32'h0);
    chk("lus_bubble_ab", {alu_a, alu_b}, 32'h0);
    chk("lus_drop", 32'(load_use_stall), 32'h0);
    tick();
    chk("lus_reload_v", 32'(ex_valid), 32'h1);
    chk("lus_reload_s", 32'(alu_sigs), 32'h5);
    chk("lus_reload_a", 32'(alu_a), 32'h0050);

    // load to r0 never causes a stall
    set_id(1, 4'b0100, 3'd1, 3'd1, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 1, 0);
    tick();
    set_id(1, 4'b0100, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 0, 3'd2, 1, 0, 0);
    #1 chk("lus_r0", 32'(load_use_stall), 32'h0);

    // stall keeps a value retiring from MEM/WB
    set_id(1, 4'b1000, 3'd1, 3'd2, 16'h00F0, 16'h0001, 16'h0, 0, 3'd7, 1, 0, 1);
    tick();
    stall = 1'b1;
    set_fwd(0, 3'd0, 16'h0, 1, 3'd2, 16'h7F43);
    set_id(1, 4'b0000, 3'd4, 3'd4, 16'h9999, 16'h9999, 16'h0, 0, 3'd4, 1, 0, 0);
    tick();
    memwb_wr_en = 1'b0;
    #1 chk("stall_keep1", 32'(alu_b), 32'h7F43);
    chk("stall_sigs", 32'(alu_sigs), 32'h8);
    tick();
    chk("stall_keep2", 32'(alu_b), 32'h7F43);
    chk("stall_rd", 32'(ex_rd_addr), 32'h7);

    // flush overrides stall
    flush = 1'b1;
    tick();
    chk("flush_wr", 32'(ex_wr_en), 32'h0);
    chk("flush_cc", 32'(ex_setcc), 32'h0);
    chk("flush_v", 32'(ex_valid), 32'h0);
    flush = 1'b0; stall = 1'b0;

    // directed sweep of forwarding combinations, model-checked each cycle
    for (int i = 0; i < 16; i++) begin
      set_id(i[0], 4'(i), 3'(i), 3'(i + 3), 16'(16'h1000 + i), 16'(16'h2000 + i),
             16'(16'h3000 + i), i[1], 3'(i + 1), i[2], 0, i[3]);
      set_fwd(i[1], 3'(i), 16'(16'hA000 + i), i[2], 3'(i + 3), 16'(16'hB000 + i));
      tick();
    end

    // asynchronous reset mid-cycle
    set_fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    set_id(1, 4'b0110, 3'd2, 3'd3, 16'h4444, 16'h5555, 16'h0, 0, 3'd6, 1, 0, 1);
    tick();
    chk("pre_rst_a", 32'(alu_a), 32'h4444);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_v", 32'(ex_valid), 32'h0);
    chk("async_rst_a", 32'(alu_a), 32'h0);
    #1 rst_n = 1'b1;
    set_id(1, 4'b0100, 3'd1, 3'd0, 16'h0123, 16'h0, 16'h0, 0, 3'd2, 1, 0, 0);
    tick();
    chk("post_rst_v", 32'(ex_valid), 32'h1);
    chk("post_rst_a", 32'(alu_a), 32'h0123);
    in_valid = 1'b0;
    tick();
    chk("invalid_bubble", 32'(ex_valid), 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
